// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encode/decode constants and enums for the addi/bne subset.
package instr_encoder_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic {
    OP_ADDI = 1'b0,
    OP_BNE  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_encoder_rv_field_pack.sv
// Combinational packer: instruction record fields -> 32-bit RV32I word,
// flagging immediates that cannot be represented in the target format.
module rv_field_pack
  import instr_encoder_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the I-type or B-type layout; illegal marks out-of-range or odd offsets.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADDI: begin
        word    = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
        illegal = (imm[12] != imm[11]);
      end
      OP_BNE: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OP_BRANCH};
        illegal = imm[0];
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded records, encodes them and writes the words
// sequentially into instruction memory starting at BASE_ADDR.
//
// state | meaning
// IDLE  | waiting for the first start pulse after reset
// LOAD  | accepting records, one registered write per accepted legal record
// DONE  | last record seen or memory full; waits for start
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [12:0]                in_imm,
  input  logic                       in_last,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [31:0]                wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     word_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]           DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(4);

  state_e                r_state;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic [CW-1:0]         r_word_count;

  logic [31:0]           w_word;
  logic                  w_illegal;
  logic [CW:0]           w_fill;
  logic [CW-1:0]         w_wc_inc;
  logic                  w_ready;
  logic                  w_accept;

  rv_field_pack u_pack (
    .op      (op_e'(in_op)),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // A write still in the output register counts against capacity.
  assign w_fill   = {1'b0, r_word_count} + (CW+1)'(r_wr_en);
  assign w_wc_inc = r_word_count + CW'(1);
  assign w_ready  = (r_state == LOAD) && (w_fill < DEPTH_W) && !start;
  assign w_accept = in_valid && w_ready;

  // FSM, address/word counters and the registered memory-write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_addr       <= BASE_C;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en && (r_word_count != DEPTH_C))
        r_word_count <= w_wc_inc;

      if (start) begin
        r_state      <= LOAD;
        r_word_count <= '0;
        r_addr       <= BASE_C;
        r_err        <= 1'b0;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) begin
              if (w_illegal) begin
                r_err <= 1'b1;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_word;
                r_addr    <= r_addr + STEP_C;
              end
              if (in_last)
                r_state <= DONE;
            end
            // Final word of a full memory is leaving the output register.
            if (r_wr_en && (w_wc_inc >= DEPTH_C))
              r_state <= DONE;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign in_ready   = w_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = (r_state == LOAD);
  assign done       = (r_state == DONE);
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule
